// File: rtl/matmul_ctrl_if.sv
// matmul_ctrl_if: operand write port, start/busy/done handshake, result
// read port and datapath operand/product buses for matmul_ctrl.
//   wr_en/wr_addr/wr_data -> operand byte write, wr_err <- dropped-write pulse
//   start -> busy/done handshake; rd_addr -> rd_data (combinational read)
//   mat_A/mat_B -> datapath operands (row-major), mat_C <- datapath products
//   irq/irq_clr present only when MATMUL_CTRL_IRQ_EN is defined
// Modports: slave = controller side, master = software/DMA + datapath side.
interface matmul_ctrl_if;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             wr_err;
    logic             start;
    logic             busy;
    logic             done;
    logic [3:0]       rd_addr;
    logic [15:0]      rd_data;
    logic [8:0][7:0]  mat_A;
    logic [8:0][7:0]  mat_B;
    logic [8:0][15:0] mat_C;
`ifdef MATMUL_CTRL_IRQ_EN
    logic             irq;
    logic             irq_clr;

    modport slave (
        input  wr_en, wr_addr, wr_data, start, rd_addr, mat_C, irq_clr,
        output wr_err, busy, done, rd_data, mat_A, mat_B, irq
    );
    modport master (
        output wr_en, wr_addr, wr_data, start, rd_addr, mat_C, irq_clr,
        input  wr_err, busy, done, rd_data, mat_A, mat_B, irq
    );
`else
    modport slave (
        input  wr_en, wr_addr, wr_data, start, rd_addr, mat_C,
        output wr_err, busy, done, rd_data, mat_A, mat_B
    );
    modport master (
        output wr_en, wr_addr, wr_data, start, rd_addr, mat_C,
        input  wr_err, busy, done, rd_data, mat_A, mat_B
    );
`endif
endinterface

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencing controller for the 3x3 8-bit matrix multiply
// datapath. Holds operands A/B, runs start/busy/done sized to MUL_LATENCY,
// and captures the nine 16-bit products into a readable result bank.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - matmul_ctrl_if.slave (write port, handshake, read port,
//            datapath operand/product buses, optional irq/irq_clr)
// Parameter: MUL_LATENCY (1..15) datapath edges from stable operands to mat_C.
// Optional feature macro: MATMUL_CTRL_IRQ_EN (sticky completion irq).
module matmul_ctrl #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    matmul_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] LAT = MUL_LATENCY[3:0];

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [8:0][7:0]  r_a;
    logic [8:0][7:0]  r_b;
    logic [8:0][15:0] r_res;
    logic             r_busy;
    logic             r_done;
    logic             r_wr_err;
    logic [15:0]      w_rd_data;
    logic [3:0]       w_b_idx;

    // Addresses 9..17 map to B[0..8]; their low nibble minus 9 (mod 16)
    // yields exactly 0..8, so no wider subtraction is needed.
    assign w_b_idx = bus.wr_addr[3:0] - 4'd9;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_wr_err <= bus.wr_en && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    // Writes in the start cycle land with the start edge
                    // and therefore belong to the new operation.
                    if (bus.wr_en) begin
                        if (bus.wr_addr < 5'd9)
                            r_a[bus.wr_addr[3:0]] <= bus.wr_data;
                        else if (bus.wr_addr < 5'd18)
                            r_b[w_b_idx] <= bus.wr_data;
                    end
                    if (bus.start) begin
                        r_state <= WAIT;
                        r_cnt   <= LAT;
                        r_busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_res   <= bus.mat_C;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MATMUL_CTRL_IRQ_EN
    logic r_irq;

    // Capture sets irq and takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_irq <= 1'b0;
        else if (r_state == CAPTURE)
            r_irq <= 1'b1;
        else if (bus.irq_clr)
            r_irq <= 1'b0;
    end

    assign bus.irq = r_irq;
`endif

    always_comb begin
        w_rd_data = '0;
        if (bus.rd_addr < 4'd9)
            w_rd_data = r_res[bus.rd_addr];
    end

    assign bus.rd_data = w_rd_data;
    assign bus.mat_A   = r_a;
    assign bus.mat_B   = r_b;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.wr_err  = r_wr_err;

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl: scoreboard bench for matmul_ctrl. Stimulus keeps shadow
// copies of A/B, computes expected products by plain matrix arithmetic and
// pushes them with the expected done cycle; a monitor pops and compares
// whenever done is seen. A behavioural datapath supplies mat_C.
module tb_matmul_ctrl;

    localparam int unsigned LAT = 1;

    typedef struct packed {
        int unsigned      cyc;
        logic [8:0][15:0] c;
    } exp_t;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int checks;
    int errors;
    exp_t sbq[$];
    int sh_a[9];
    int sh_b[9];

    matmul_ctrl_if bus();

    matmul_ctrl #(.MUL_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: registered product, LAT edges of latency.
    function automatic logic [8:0][15:0] dp(logic [8:0][7:0] a, logic [8:0][7:0] b);
        logic [8:0][15:0] r;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int unsigned s;
                s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(a[i*3+k]) * int'(b[k*3+j]);
                r[i*3+j] = s[15:0];
            end
        return r;
    endfunction

    logic [8:0][15:0] dp_pipe [LAT];
    initial for (int j = 0; j < LAT; j++) dp_pipe[j] = '0;
    always @(posedge clk) begin
        dp_pipe[0] <= dp(bus.mat_A, bus.mat_B);
        for (int j = 1; j < LAT; j++) dp_pipe[j] <= dp_pipe[j-1];
    end
    assign bus.mat_C = dp_pipe[LAT-1];

    // Reference: C = A x B over shadow operands, reduced mod 65536.
    function automatic logic [8:0][15:0] model();
        logic [8:0][15:0] r;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) s += sh_a[i*3+k] * sh_b[k*3+j];
                r[i*3+j] = 16'(s % 65536);
            end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic shadow_wr(input logic [4:0] addr, input logic [7:0] data);
        if (addr < 9) sh_a[addr] = int'(data);
        else if (addr < 18) sh_b[addr-9] = int'(data);
    endtask

    // Monitor: compare every done against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", int'(cyc), int'(e.cyc));
                chk("busy_at_done", int'(bus.busy), 0);
                for (int i = 0; i < 9; i++) begin
                    bus.rd_addr = 4'(i);
                    #1;
                    chk($sformatf("result[%0d]", i), int'(bus.rd_data), int'(e.c[i]));
                end
            end
        end
    end

    // Called at a negedge; one accepted/dropped write cycle.
    task automatic wr(input logic [4:0] addr, input logic [7:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        @(posedge clk); #1;
        chk("wr_err_idle", int'(bus.wr_err), 0);
        shadow_wr(addr, data);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the start edge.
    task automatic op_start(input bit push, input bit do_wr,
                            input logic [4:0] addr, input logic [7:0] data);
        exp_t e;
        bus.start = 1'b1;
        if (do_wr) begin
            bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
            shadow_wr(addr, data);
        end
        e.c = model();
        @(posedge clk); #1;
        e.cyc = cyc + LAT + 1;
        if (push) sbq.push_back(e);
        chk("busy_after_start", int'(bus.busy), 1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", int'(n < 50), 1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic load_all(input bit rnd, input int av, input int bv);
        for (int i = 0; i < 18; i++) begin
            logic [7:0] d;
            if (rnd) d = 8'($urandom);
            else d = (i < 9) ? 8'(av) : 8'(bv);
            wr(5'(i), d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 9; i++) begin sh_a[i] = 0; sh_b[i] = 0; end
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.rd_addr = '0;
`ifdef MATMUL_CTRL_IRQ_EN
        bus.irq_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_wr_err", int'(bus.wr_err), 0);
        chk("rst_mat_A", int'(bus.mat_A == '0), 1);
        chk("rst_mat_B", int'(bus.mat_B == '0), 1);
`ifdef MATMUL_CTRL_IRQ_EN
        chk("rst_irq", int'(bus.irq), 0);
`endif
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr = 4'(i); #1;
            chk("rst_rd_data", int'(bus.rd_data), 0);
        end
        @(negedge clk);

        // Identity x 1..9
        for (int i = 0; i < 9; i++) wr(5'(i), (i % 4 == 0) ? 8'd1 : 8'd0);
        for (int i = 0; i < 9; i++) wr(5'(9 + i), 8'(i + 1));
        op_start(1'b1, 1'b0, '0, '0);
        wait_idle();
`ifdef MATMUL_CTRL_IRQ_EN
        chk("irq_set", int'(bus.irq), 1);
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
        chk("irq_clr", int'(bus.irq), 0);
`endif

        // B[4]=3 written in the start cycle, A still identity
        op_start(1'b1, 1'b1, 5'd13, 8'd3);
        wait_idle();

        // All 255: every result 195075 mod 65536 = 64003
        load_all(1'b0, 255, 255);
        chk("model_64003", int'(model() == {9{16'd64003}}), 1);
        op_start(1'b1, 1'b0, '0, '0);
        // Write in WAIT and CAPTURE dropped; start there ignored.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 8'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        chk("wr_err_wait", int'(bus.wr_err), 1);
        chk("mat_A0_kept", int'(bus.mat_A[0]), sh_a[0]);
        @(negedge clk);
        bus.wr_addr = 5'd10; bus.wr_data = 8'd9;
        @(posedge clk); #1;
        chk("wr_err_capture", int'(bus.wr_err), 1);
        chk("mat_B1_kept", int'(bus.mat_B[1]), sh_b[1]);
        @(negedge clk);
        bus.wr_en = 1'b0; bus.start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("busy_no_extra", int'(bus.busy), 0);

`ifdef MATMUL_CTRL_IRQ_EN
        // Clear held across capture: set wins.
        op_start(1'b1, 1'b0, '0, '0);
        bus.irq_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("irq_set_wins", int'(bus.irq), 1);
        bus.irq_clr = 1'b0;
        wait_idle();
`endif

        // Randomized operations, including ignored addresses 18..31.
        for (int t = 0; t < 10; t++) begin
            load_all(1'b1, 0, 0);
            wr(5'($urandom_range(18, 31)), 8'($urandom));
            op_start(1'b1, 1'($urandom), 5'($urandom_range(0, 31)), 8'($urandom));
            wait_idle();
            bus.rd_addr = 4'($urandom_range(9, 15)); #1;
            chk("rd_oob_zero", int'(bus.rd_data), 0);
        end

        // Reset during WAIT: no done, everything cleared.
        op_start(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", int'(bus.busy), 0);
        chk("rstw_mat_A", int'(bus.mat_A == '0), 1);
        for (int i = 0; i < 9; i++) begin
            bus.rd_addr = 4'(i); #1;
            chk("rstw_result", int'(bus.rd_data), 0);
        end
        for (int i = 0; i < 9; i++) begin sh_a[i] = 0; sh_b[i] = 0; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstw_no_done", int'(bus.done), 0);
        end

        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
